run_monitor: RTL and testbench

RUN_MONITOR -- requirements
Module: run_monitor

---
 rtl/monitor_pkg.sv | 22 ++
 rtl/rf_shadow.sv | 33 +++
 rtl/run_monitor.sv | 119 +++++++++++
 tb/tb_run_monitor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/monitor_pkg.sv
// Shared types for the run monitor: FSM states, failure causes and datapath widths.
package monitor_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK,
    ST_PASS,
    ST_FAIL
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_TIMEOUT  = 2'd2,
    FC_WDOG     = 2'd3
  } fail_code_t;

endpackage

// File: rtl/rf_shadow.sv
// Shadow copy of the CPU register file: one write port, one asynchronous read port,
// r0 hardwired to zero. Built from flops so every entry can be cleared on reset.
module rf_shadow
  import monitor_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_idx,
  input  logic [XLEN-1:0]      wr_data,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic [XLEN-1:0]      rd_data
);

  logic [XLEN-1:0] regs [32];

  // NOTE: the array is reset explicitly, which forces flops instead of a RAM macro;
  // a run must never see stale values from the previous run.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wr_en && (wr_idx == REG_IDX_W'(i))) regs[i] <= wr_data;
      end
    end
  end

  assign rd_data = (rd_idx == '0) ? '0 : regs[rd_idx];

endmodule

// File: rtl/run_monitor.sv
// Watches a CPU run: shadows register writes, enforces a cycle budget and a write
// watchdog, and on halt compares one register against the expected value.
module run_monitor
  import monitor_pkg::*;
#(
  parameter int unsigned     MAX_CYC  = 1000,
  parameter int unsigned     WDOG_CYC = 64,
  parameter int unsigned     EXP_REG  = 10,
  parameter logic [XLEN-1:0] EXP_VAL  = 32'd45
) (
  input  logic                 clk,
  input  logic                 reset_async,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_idx,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 cpu_halt,
  output logic                 passed,
  output logic                 failed,
  output logic [1:0]           fail_code,
  output logic [XLEN-1:0]      cyc_cnt
);

  logic [1:0]      rst_sync;
  logic            rst_n;
  state_t          state_q, state_d;
  fail_code_t      code_q, code_d;
  logic [XLEN-1:0] cyc_q;
  logic [XLEN-1:0] wdog_q;
  logic            wr_accept;
  logic [XLEN-1:0] chk_data;

  // Assertion is immediate; release is delayed two edges so no flop leaves reset
  // on a metastable deassertion.
  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) rst_sync <= '0;
    else              rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  assign wr_accept = (state_q == ST_RUN) && wr_en && (wr_idx != '0);

  rf_shadow u_rf_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_accept),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_idx  (REG_IDX_W'(EXP_REG)),
    .rd_data (chk_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        // Halt wins over timeout, timeout wins over watchdog.
        if (cpu_halt) begin
          state_d = ST_CHECK;
        end else if (cyc_q >= MAX_CYC) begin
          state_d = ST_FAIL;
          code_d  = FC_TIMEOUT;
        end else if (wdog_q >= WDOG_CYC) begin
          state_d = ST_FAIL;
          code_d  = FC_WDOG;
        end
      end
      ST_CHECK: begin
        if (chk_data == EXP_VAL) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_FAIL;
          code_d  = FC_MISMATCH;
        end
      end
      default: ;
    endcase
  end

  // Counts only cycles spent in RUN/CHECK, so the first RUN cycle reads 1 and the
  // value freezes on entry to a terminal state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else if (((state_d == ST_RUN) || (state_d == ST_CHECK)) && (cyc_q != '1)) begin
      cyc_q <= cyc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (state_q == ST_RUN) begin
      wdog_q <= wr_accept ? '0 : (wdog_q + 1'b1);
    end
  end

  always_comb begin
    passed    = (state_q == ST_PASS);
    failed    = (state_q == ST_FAIL);
    fail_code = (state_q == ST_FAIL) ? code_q : FC_NONE;
    cyc_cnt   = cyc_q;
  end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: pass, mismatch, timeout, watchdog, same-cycle
// write+halt, halt-over-timeout priority and mid-run reset with an r0 check.
module tb_run_monitor;

  logic        clk;
  logic        reset_async;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic        cpu_halt;

  logic        passed, failed;
  logic [1:0]  fail_code;
  logic [31:0] cyc_cnt;
  logic        z_passed, z_failed;
  logic [1:0]  z_fail_code;
  logic [31:0] z_cyc_cnt;

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  run_monitor #(.MAX_CYC(100), .WDOG_CYC(64), .EXP_REG(10), .EXP_VAL(32'd45)) dut (
    .clk         (clk),
    .reset_async (reset_async),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .cpu_halt    (cpu_halt),
    .passed      (passed),
    .failed      (failed),
    .fail_code   (fail_code),
    .cyc_cnt     (cyc_cnt)
  );

  run_monitor #(.MAX_CYC(100), .WDOG_CYC(64), .EXP_REG(0), .EXP_VAL(32'd0)) dut_z (
    .clk         (clk),
    .reset_async (reset_async),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .cpu_halt    (cpu_halt),
    .passed      (z_passed),
    .failed      (z_failed),
    .fail_code   (z_fail_code),
    .cyc_cnt     (z_cyc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic run_to(input int target);
    while (cur < target) step();
  endtask

  task automatic write_reg(input int at, input logic [4:0] idx, input logic [31:0] data);
    run_to(at);
    wr_en = 1'b1; wr_idx = idx; wr_data = data;
    step();
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
  endtask

  task automatic halt_at(input int at);
    run_to(at);
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
  endtask

  // Asserts reset between clock edges, checks outputs cleared at once, then
  // releases and lands in the first RUN cycle (cur = 1).
  task automatic start_run(input string tag);
    reset_async = 1'b0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0; cpu_halt = 1'b0;
    #2;
    check({tag, "_rst_passed"}, passed, 0);
    check({tag, "_rst_failed"}, failed, 0);
    check({tag, "_rst_code"}, fail_code, 0);
    check({tag, "_rst_cyc"}, cyc_cnt, 0);
    reset_async = 1'b1;
    cur = -2;
    step();
    step();
    check({tag, "_idle_cyc"}, cyc_cnt, 0);
    step();
    check({tag, "_first_run_cyc"}, cyc_cnt, 1);
  endtask

  initial begin
    reset_async = 1'b1;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0; cpu_halt = 1'b0;
    #1;

    // Nominal pass: r10=45 at 20, halt at 30.
    start_run("pass");
    write_reg(20, 5'd10, 32'd45);
    halt_at(30);
    check("pass_latency_passed", passed, 0);
    check("pass_check_cyc", cyc_cnt, 31);
    step();
    check("pass_passed", passed, 1);
    check("pass_failed", failed, 0);
    check("pass_code", fail_code, 0);
    check("pass_cyc_frozen", cyc_cnt, 31);
    check("pass_zero_reg_passed", z_passed, 1);
    cpu_halt = 1'b1; wr_en = 1'b1; wr_idx = 5'd10; wr_data = 32'd0;
    repeat (5) step();
    cpu_halt = 1'b0; wr_en = 1'b0;
    check("pass_terminal_passed", passed, 1);
    check("pass_terminal_cyc", cyc_cnt, 31);

    // Mismatch: r10=44 then halt at 15.
    start_run("mism");
    write_reg(10, 5'd10, 32'd44);
    halt_at(15);
    check("mism_latency_failed", failed, 0);
    step();
    check("mism_failed", failed, 1);
    check("mism_code", fail_code, 1);
    check("mism_passed", passed, 0);
    check("mism_cyc", cyc_cnt, 16);

    // Timeout: writes every 10 cycles, never halts.
    start_run("tmo");
    for (int c = 5; c <= 95; c += 10) write_reg(c, 5'd1, 32'(c));
    run_to(100);
    check("tmo_before_failed", failed, 0);
    check("tmo_before_cyc", cyc_cnt, 100);
    step();
    check("tmo_failed", failed, 1);
    check("tmo_code", fail_code, 2);
    check("tmo_passed", passed, 0);
    check("tmo_cyc", cyc_cnt, 100);

    // Watchdog: one write at 5, then silence.
    start_run("wdog");
    write_reg(5, 5'd3, 32'h1234);
    run_to(70);
    check("wdog_before_failed", failed, 0);
    step();
    check("wdog_failed", failed, 1);
    check("wdog_code", fail_code, 3);
    check("wdog_cyc", cyc_cnt, 70);

    // Write and halt in the same cycle.
    start_run("same");
    run_to(8);
    wr_en = 1'b1; wr_idx = 5'd10; wr_data = 32'd45; cpu_halt = 1'b1;
    step();
    wr_en = 1'b0; cpu_halt = 1'b0;
    step();
    check("same_passed", passed, 1);
    check("same_failed", failed, 0);
    check("same_cyc", cyc_cnt, 9);

    // Halt coincides with the timeout cycle: halt wins.
    start_run("prio");
    write_reg(50, 5'd10, 32'd45);
    halt_at(100);
    check("prio_check_failed", failed, 0);
    check("prio_check_cyc", cyc_cnt, 101);
    step();
    check("prio_passed", passed, 1);
    check("prio_cyc", cyc_cnt, 101);

    // Reset at cycle 50 of a run, then a clean run; r0 writes are ignored.
    start_run("mid");
    write_reg(20, 5'd10, 32'd45);
    run_to(50);
    start_run("mid_reset");
    write_reg(5, 5'd10, 32'd45);
    write_reg(6, 5'd0, 32'd45);
    halt_at(10);
    step();
    check("mid_second_passed", passed, 1);
    check("mid_second_cyc", cyc_cnt, 11);
    check("mid_r0_zero_passed", z_passed, 1);
    check("mid_r0_zero_failed", z_failed, 0);

    // Shadow file is cleared by reset: halting without writes mismatches.
    start_run("clr");
    halt_at(3);
    step();
    check("clr_failed", failed, 1);
    check("clr_code", fail_code, 1);
    check("clr_zero_reg_passed", z_passed, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
